seed_scheduler: RTL and testbench

- Sequences the TRNG seed path: accepts seed requests from NUM_REQ DRBG consumers and arbitrates round-robin.
- Fires one collection on the TRNG seed system per grant, then health-checks the returned seed.
- Delivers a passing seed to the granted requester over a valid/ack handshake. Retries failed checks and timeouts, then raises a sticky alarm.
- Sits between the TRNG seed system and the DRBG instances.

---
 rtl/seed_sched_pkg.sv | 25 ++
 rtl/seed_scheduler_rr_arbiter.sv | 31 +++
 rtl/seed_scheduler.sv | 169 ++++++++++++++++
 tb/tb_seed_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_sched_pkg.sv
// Shared types and constants for the TRNG seed scheduler.
package seed_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    CHECK   = 3'd3,
    DELIVER = 3'd4,
    FAIL    = 3'd5
  } state_t;

  // Default seed width of the TRNG seed system and its stuck-high pattern.
  localparam int DEF_SEED_WIDTH = 256;
  localparam logic [DEF_SEED_WIDTH-1:0] ALL_ONES = '1;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int tmo_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int TMO_W = tmo_width(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/seed_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               found
);

  logic [PTR_W-1:0] cand;

  // Scan NUM_REQ positions starting at rr_ptr; the first set request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/seed_scheduler.sv
// Seed path sequencer between the TRNG seed system and the DRBG consumers:
// grants one requester, runs collection attempts with health checks and a
// per-attempt timeout, delivers a passing seed, or latches a sticky alarm.
//
// state   | meaning
// IDLE    | no transaction; grants the round-robin winner when any req is set
// START   | launches a collection (trng_start seen next cycle), clears timer
// WAIT    | waits for trng_seed_ready; timer expiry counts as a failed attempt
// CHECK   | health check of the captured seed; deliver, retry or give up
// DELIVER | seed_valid held until seed_ack or the winner drops its request
// FAIL    | sticky alarm, requests ignored until alarm_clr
module seed_scheduler
  import seed_sched_pkg::*;
#(
  parameter int SEED_WIDTH     = 256,
  parameter int NUM_REQ        = 4,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [SEED_WIDTH-1:0] seed_out,
  output logic                  seed_valid,
  input  logic                  seed_ack,
  output logic                  trng_start,
  input  logic [SEED_WIDTH-1:0] trng_seed,
  input  logic                  trng_seed_ready,
  output logic                  busy,
  output logic                  alarm,
  input  logic                  alarm_clr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = tmo_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        winner;
  logic [PTR_W-1:0]        ptr_after;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [PTR_W-1:0]        arb_idx;
  logic                    arb_found;
  logic [3:0]              retry_cnt;
  logic [3:0]              retry_next;
  logic [CNT_W-1:0]        tmo_cnt;
  logic                    tmo_hit;
  logic [SEED_WIDTH-1:0]   seed_reg;
  logic [SEED_WIDTH-1:0]   last_seed;
  logic                    last_vld;
  logic                    seed_bad;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .found  (arb_found)
  );

  // A timed-out attempt has no seed worth checking, so it fails outright.
  assign seed_bad   = tmo_hit
                    || (seed_reg == '0)
                    || (seed_reg == '1)
                    || (last_vld && (seed_reg == last_seed));
  assign retry_next = retry_cnt + 4'd1;
  assign ptr_after  = (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);

  // Sequencing FSM; every output is registered together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      seed_out   <= '0;
      seed_valid <= 1'b0;
      trng_start <= 1'b0;
      busy       <= 1'b0;
      alarm      <= 1'b0;
      rr_ptr     <= '0;
      winner     <= '0;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      tmo_hit    <= 1'b0;
      seed_reg   <= '0;
      last_seed  <= '0;
      last_vld   <= 1'b0;
    end else begin
      trng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            gnt       <= arb_gnt;
            winner    <= arb_idx;
            retry_cnt <= '0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          trng_start <= 1'b1;
          tmo_cnt    <= '0;
          tmo_hit    <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (trng_seed_ready) begin
            seed_reg <= trng_seed;
            state    <= CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_hit <= 1'b1;
            state   <= CHECK;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          if (seed_bad) begin
            retry_cnt <= retry_next;
            if (retry_next < RETRY_LIMIT) begin
              state <= START;
            end else begin
              alarm <= 1'b1;
              gnt   <= '0;
              busy  <= 1'b0;
              state <= FAIL;
            end
          end else begin
            seed_out   <= seed_reg;
            seed_valid <= 1'b1;
            state      <= DELIVER;
          end
        end
        DELIVER: begin
          // Ack wins over a simultaneous request drop.
          if (seed_ack || !req[winner]) begin
            if (seed_ack) begin
              last_seed <= seed_reg;
              last_vld  <= 1'b1;
            end
            gnt        <= '0;
            seed_out   <= '0;
            seed_valid <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= ptr_after;
            state      <= IDLE;
          end
        end
        FAIL: begin
          if (alarm_clr) begin
            alarm  <= 1'b0;
            rr_ptr <= ptr_after;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seed_scheduler.sv
// Self-checking bench for seed_scheduler: directed timing sequences, a
// transaction table, and randomized transactions against a request/seed model.
module tb_seed_scheduler;

  localparam int SW  = 256;
  localparam int NR  = 4;
  localparam int TMO = 16;

  typedef struct packed {
    logic          mute;
    logic [SW-1:0] seed;
  } att_t;

  typedef struct packed {
    logic [3:0]    rq;
    att_t [2:0]    at;
    int            nat;
    bit            drop;
    logic [3:0]    egnt;
    int            estarts;
    bit            ealarm;
    logic [SW-1:0] eseed;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [SW-1:0] seed_out;
  logic          seed_valid;
  logic          seed_ack;
  logic          trng_start;
  logic [SW-1:0] trng_seed;
  logic          trng_seed_ready;
  logic          busy;
  logic          alarm;
  logic          alarm_clr;

  int   checks;
  int   failures;
  int   trng_delay;
  att_t att_q [$];
  vec_t tbl [10];

  seed_scheduler #(
    .SEED_WIDTH     (SW),
    .NUM_REQ        (NR),
    .MAX_RETRY      (3),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .gnt             (gnt),
    .seed_out        (seed_out),
    .seed_valid      (seed_valid),
    .seed_ack        (seed_ack),
    .trng_start      (trng_start),
    .trng_seed       (trng_seed),
    .trng_seed_ready (trng_seed_ready),
    .busy            (busy),
    .alarm           (alarm),
    .alarm_clr       (alarm_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic att_t good(input logic [SW-1:0] s);
    att_t a;
    a.mute = 1'b0;
    a.seed = s;
    return a;
  endfunction

  function automatic att_t mute();
    att_t a;
    a.mute = 1'b1;
    a.seed = '0;
    return a;
  endfunction

  function automatic logic [SW-1:0] sc(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {8{w}};
  endfunction

  function automatic logic [SW-1:0] rand_seed();
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < SW / 32; i++) r = {r[SW-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic vec_t mkv(input logic [3:0] rq, input att_t a0, input att_t a1,
                               input att_t a2, input int nat, input bit drop,
                               input logic [3:0] eg, input int es, input bit ea,
                               input logic [SW-1:0] esd);
    vec_t v;
    v.rq = rq; v.at[0] = a0; v.at[1] = a1; v.at[2] = a2; v.nat = nat;
    v.drop = drop; v.egnt = eg; v.estarts = es; v.ealarm = ea; v.eseed = esd;
    return v;
  endfunction

  // Round-robin rule: first requester at or after ptr, wrapping.
  function automatic int pick(input logic [3:0] rq, input int ptr);
    for (int i = 0; i < NR; i++) if (rq[(ptr + i) % NR]) return (ptr + i) % NR;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // TRNG seed system model: one queued attempt per trng_start pulse.
  initial begin
    att_t a;
    trng_seed_ready = 1'b0;
    trng_seed = '0;
    forever begin
      @(negedge clk);
      trng_seed_ready = 1'b0;
      if (rst_n && trng_start) begin
        a = mute();
        if (att_q.size() > 0) a = att_q.pop_front();
        if (!a.mute) begin
          repeat (trng_delay) @(negedge clk);
          trng_seed = a.seed;
          trng_seed_ready = 1'b1;
        end
      end
    end
  end

  // One whole transaction; called at a negedge with the DUT idle.
  task automatic run_txn(input string tag, input logic [3:0] rq, input bit drop,
                         input logic [3:0] egnt, input int estarts, input bit ealarm,
                         input logic [SW-1:0] eseed);
    int n;
    int starts;
    int hold;
    logic [SW-1:0] held;
    req = rq;
    @(negedge clk);
    chk({tag, "_gnt"}, gnt, egnt);
    starts = 0;
    n = 0;
    while (!seed_valid && !alarm && n < 300) begin
      if (trng_start) starts++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_bounded"}, n < 300, 1);
    chk({tag, "_starts"}, starts, estarts);
    chk({tag, "_alarm"}, alarm, ealarm);
    if (ealarm) begin
      chk({tag, "_fail_gnt"}, gnt, 0);
      chk({tag, "_fail_busy"}, busy, 0);
      repeat (3) @(negedge clk);
      chk({tag, "_no_service"}, {gnt, seed_valid, alarm}, {4'b0000, 1'b0, 1'b1});
      alarm_clr = 1'b1;
      @(negedge clk);
      alarm_clr = 1'b0;
      chk({tag, "_clr"}, {alarm, busy}, 0);
    end else begin
      chk({tag, "_seed"}, seed_out, eseed);
      chk({tag, "_dlv_gnt"}, gnt, egnt);
      held = seed_out;
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clk);
        chk({tag, "_hold"}, {seed_valid, seed_out}, {1'b1, held});
      end
      if (drop) req = rq & ~egnt;
      else seed_ack = 1'b1;
      @(negedge clk);
      seed_ack = 1'b0;
      chk({tag, "_end"}, {seed_valid, gnt, busy}, 0);
    end
  endtask

  initial begin
    int n;
    int np;
    int pc [4];
    int m_ptr;
    logic [SW-1:0] m_last;
    bit m_last_vld;
    logic [SW-1:0] s_a5;
    logic [SW-1:0] s_12;

    checks = 0; failures = 0;
    rst_n = 1'b0; req = '0; seed_ack = 1'b0; alarm_clr = 1'b0; trng_delay = 3;
    s_a5 = {32{8'hA5}};
    s_12 = {16{16'h1234}};

    tbl[0] = mkv(4'b1111, good(sc(1)), mute(), mute(), 1, 0, 4'b0010, 1, 0, sc(1));
    tbl[1] = mkv(4'b1111, good(sc(2)), mute(), mute(), 1, 0, 4'b0100, 1, 0, sc(2));
    tbl[2] = mkv(4'b1111, good(sc(3)), mute(), mute(), 1, 0, 4'b1000, 1, 0, sc(3));
    tbl[3] = mkv(4'b1111, good(sc(4)), mute(), mute(), 1, 0, 4'b0001, 1, 0, sc(4));
    tbl[4] = mkv(4'b1111, good('0), good('1), good(s_12), 3, 0, 4'b0010, 3, 0, s_12);
    tbl[5] = mkv(4'b0100, good(s_12), good(s_12), good(s_12), 3, 0, 4'b0100, 3, 1, '0);
    tbl[6] = mkv(4'b0101, good(sc(5)), mute(), mute(), 1, 0, 4'b0001, 1, 0, sc(5));
    tbl[7] = mkv(4'b0011, mute(), good(sc(6)), mute(), 2, 1, 4'b0010, 2, 0, sc(6));
    tbl[8] = mkv(4'b0001, good(sc(5)), good(sc(7)), mute(), 2, 0, 4'b0001, 2, 0, sc(7));
    tbl[9] = mkv(4'b1000, good(sc(8)), mute(), mute(), 1, 0, 4'b1000, 1, 0, sc(8));

    repeat (3) @(negedge clk);
    chk("rst_outputs", {gnt, seed_valid, trng_start, busy, alarm}, 0);
    chk("rst_seed_out", seed_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: grant, start pulse and delivery latency.
    trng_delay = 5;
    att_q.push_back(good(s_a5));
    req = 4'b0001;
    @(negedge clk);
    chk("a_gnt", {gnt, busy, trng_start}, {4'b0001, 1'b1, 1'b0});
    @(negedge clk);
    chk("a_start", trng_start, 1);
    @(negedge clk);
    chk("a_start_pulse", trng_start, 0);
    repeat (5) @(negedge clk);
    chk("a_valid_early", seed_valid, 0);
    @(negedge clk);
    chk("a_valid", {seed_valid, seed_out}, {1'b1, s_a5});
    seed_ack = 1'b1;
    @(negedge clk);
    seed_ack = 1'b0;
    req = '0;
    chk("a_done", {gnt, busy, seed_valid}, 0);

    // Transaction table: round-robin, retries, repeat alarm, drop, wrap.
    for (int i = 0; i < 10; i++) begin
      for (int a = 0; a < tbl[i].nat; a++) att_q.push_back(tbl[i].at[a]);
      trng_delay = 3;
      run_txn($sformatf("tbl%0d", i), tbl[i].rq, tbl[i].drop, tbl[i].egnt,
              tbl[i].estarts, tbl[i].ealarm, tbl[i].eseed);
    end

    // Timeout: pulses 18 cycles apart, alarm 17 cycles after the third.
    repeat (3) att_q.push_back(mute());
    req = 4'b0010;
    @(negedge clk);
    chk("tmo_gnt", gnt, 4'b0010);
    n = 0; np = 0;
    while (!alarm && n < 100) begin
      if (trng_start && np < 4) begin pc[np] = n; np++; end
      @(negedge clk);
      n++;
    end
    chk("tmo_pulses", np, 3);
    chk("tmo_gap1", pc[1] - pc[0], 18);
    chk("tmo_gap2", pc[2] - pc[1], 18);
    chk("tmo_alarm_at", n - pc[2], 17);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    chk("tmo_clr", alarm, 0);

    // Reset while waiting on the TRNG.
    att_q.push_back(mute());
    req = 4'b0100;
    n = 0;
    while (!trng_start && n < 20) begin @(negedge clk); n++; end
    chk("rstw_start_seen", n < 20, 1);
    repeat (3) @(negedge clk);
    chk("rstw_busy", {busy, gnt}, {1'b1, 4'b0100});
    rst_n = 1'b0;
    #1;
    chk("rstw_outputs", {gnt, seed_valid, trng_start, busy, alarm}, 0);
    chk("rstw_seed_out", seed_out, 0);
    req = '0;
    att_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset forgot the previous seed, so sc(8) is accepted again.
    att_q.push_back(good(sc(8)));
    trng_delay = 2;
    run_txn("post_rst", 4'b0001, 0, 4'b0001, 1, 0, sc(8));
    m_ptr = 1; m_last = sc(8); m_last_vld = 1'b1;

    // Randomized transactions against the request/seed model.
    for (int t = 0; t < 30; t++) begin
      logic [3:0] rq;
      logic [SW-1:0] gs;
      int w;
      int nbad;
      bit al;
      bit dr;
      rq = 4'($urandom_range(1, 15));
      w = pick(rq, m_ptr);
      al = ($urandom_range(0, 7) == 0);
      nbad = al ? 3 : int'($urandom_range(0, 2));
      gs = rand_seed();
      while (gs == '0 || gs == '1 || (m_last_vld && gs == m_last)) gs = rand_seed();
      trng_delay = $urandom_range(1, 12);
      for (int a = 0; a < nbad; a++) begin
        case ($urandom_range(0, 3))
          0: att_q.push_back(good('0));
          1: att_q.push_back(good('1));
          2: att_q.push_back(mute());
          default: att_q.push_back(good(m_last_vld ? m_last : '0));
        endcase
      end
      if (!al) att_q.push_back(good(gs));
      dr = !al && ($urandom_range(0, 4) == 0);
      run_txn($sformatf("rnd%0d", t), rq, dr, 4'(1 << w), al ? 3 : nbad + 1, al, gs);
      m_ptr = (w + 1) % NR;
      if (!al && !dr) begin m_last = gs; m_last_vld = 1'b1; end
    end

    req = '0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
